twi_slave: RTL and testbench
============================

Name: twi_slave

Overview:
- TWI (I2C) responder/target: the other end of the TWI master driving scl/sda in the SchoolMIPS system.
- Holds a bank of 2**REG_AW 8-bit registers that an external master can write and read over the bus, using a register pointer that auto-increments.
- Register contents are exposed to local logic through a combinational read port and a write-event pulse, for use on the board as a loopback target.
- Single clock domain; scl/sda are sampled by oversampling, so clk must be at least 10x the SCL rate.

Parameters:
SLAVE_ADDR, 7'h28, 7-bit bus address this block responds to.
REG_AW, 2, register-index width; the bank holds 2**REG_AW bytes.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
scl_i  in  1  SCL line as seen at the pad (asynchronous).
sda_i  in  1  SDA line as seen at the pad (asynchronous).
sda_oe  out  1  1 = pull SDA low; 0 = release SDA. Open-drain; the pad ties the pin to 0 when this is 1, else Z.
reg_addr  in  REG_AW  local read index.
reg_data  out  8  register[reg_addr], combinational.
wr_valid  out  1  one-cycle pulse when a bus write updates a register.
wr_addr  out  REG_AW  index written; valid with wr_valid.
busy  out  1  1 from an address match until STOP, a repeated START, or NACK-exit.

Behaviour:
- Reset: all registers 0x00, pointer 0, sda_oe 0, wr_valid 0, wr_addr 0, busy 0, state IDLE, bit counter 0.
- Synchronisation:
  - scl_i and sda_i each pass through a 2-flop synchroniser and then a 1-flop history register.
  - Edges and conditions are detected on the synchronised values:
    - scl_rise / scl_fall: SCL edges.
    - START: SDA falls while SCL is high.
    - STOP: SDA rises while SCL is high.
- Bit handling:
  - Data is MSB first.
  - Receive bits are sampled on scl_rise.
  - Transmit bits and ACK changes are applied on the clk cycle after scl_fall is detected.
- States:
  - IDLE: ignores everything except START.
  - ADDR: shifts in 8 bits (7-bit address plus R/W). After the 8th scl_rise:
    - match -> ACK_A;
    - mismatch -> IDLE, and SDA is never driven.
  - ACK_A: on scl_fall, sda_oe=1 and busy=1. On the next scl_fall, sda_oe=0.
    - R/W=0 -> PTR.
    - R/W=1 -> TX, and the first bit of register[ptr] is driven.
  - PTR: receives 1 byte; ptr <= byte[REG_AW-1:0], upper bits ignored. Then goes to ACK_W.
  - WDATA: receives 1 byte. Then register[ptr] <= byte, wr_valid=1 for one cycle, wr_addr=ptr, ptr <= ptr+1 (wraps modulo 2**REG_AW). Then goes to ACK_W.
  - ACK_W: same ACK timing as ACK_A, then goes to WDATA.
  - TX: drives sda_oe = ~bit (0 bit -> pull low). After 8 bits, on scl_fall sda_oe=0 and ptr <= ptr+1 (wrap). Then goes to MACK.
  - MACK: samples SDA on scl_rise.
    - 0 (ACK) -> TX with the next byte; its first bit is driven on the following scl_fall.
    - 1 (NACK) -> IDLE with busy=0.
- Overrides:
  - STOP in any state -> IDLE; sda_oe=0, busy=0, pointer retained.
  - START (including a repeated START) in any state -> ADDR; bit counter cleared, sda_oe=0, pointer retained. This permits the write-pointer / repeated-START / read sequence.
  - STOP/START detection takes priority over the bit sample in the same cycle.
- Write port: a local read of reg_addr in the same cycle as a bus write returns the old value; the new value is visible on the next cycle.
- Reset mid-transfer: state returns to IDLE at once, SDA is released, and registers are cleared.
- Clock stretching: never performed.

Optional Feature:
- Macro: TWI_SLAVE_FILTER_EN.
- Defined:
  - Each synchronised line passes through a 3-sample stability filter; the filtered value changes only after 3 consecutive equal samples.
  - Pulses shorter than 3 clk cycles are rejected.
  - All detection latency increases by 2 cycles.
- Not defined: the raw synchroniser output feeds edge detection directly.

Test Plan:
- Write with pointer: START, 0x50 (addr 0x28, W), 0x01, 0xA5, 0x3C, STOP -> ACK on every byte; reg1=0xA5, reg2=0x3C; two wr_valid pulses with wr_addr 1 then 2; busy low after STOP.
- Read via repeated START: START, 0x50, 0x01, repeated START, 0x51, read 3 bytes with master ACK, ACK, NACK, STOP -> bytes 0xA5, 0x3C, 0x00; pointer ends at 0 (wrap from 3); sda_oe=0 after NACK.
- Address mismatch: START, 0x52, 0xFF, STOP -> sda_oe stays 0 for the whole transfer; no wr_valid; busy stays 0.
- Wrap-around: write pointer 0x03, data 0x11, 0x22 -> reg3=0x11, reg0=0x22.
- Abort: STOP after 4 data bits of a write byte -> no register change, state IDLE, sda_oe=0. Also: assert rst during a TX byte -> sda_oe=0 and all registers 0x00 on the next cycle.
- With TWI_SLAVE_FILTER_EN: a 2-cycle low glitch on SDA while SCL is high during IDLE -> no START detected, state stays IDLE. Without the macro, the same stimulus is detected as a START.

Source files
------------

// File: rtl/twi_slave.sv
// TWI (I2C) target with a 2**REG_AW byte register bank and an auto-incrementing pointer.
// Define TWI_SLAVE_FILTER_EN to add a 3-sample glitch filter on the synchronised SCL/SDA.
module twi_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h28,
  parameter int         REG_AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_data,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic              busy,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_PTR, ST_WDATA, ST_ACK_W, ST_TX, ST_MACK
  } state_t;

  // Line conditioning: bit [1] of each sync pair is the synchronised value.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;
  logic       scl_cur, sda_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_cur;
      sda_hist_q <= sda_cur;
    end
  end

`ifdef TWI_SLAVE_FILTER_EN
  // The filtered level follows the input only once three consecutive samples agree.
  logic [1:0] scl_prev_q, sda_prev_q;
  logic       scl_flt_q, sda_flt_q;

  always_comb begin
    scl_cur = scl_flt_q;
    sda_cur = sda_flt_q;
    if (scl_sync_q[1] == scl_prev_q[0] && scl_prev_q[0] == scl_prev_q[1]) scl_cur = scl_sync_q[1];
    if (sda_sync_q[1] == sda_prev_q[0] && sda_prev_q[0] == sda_prev_q[1]) sda_cur = sda_sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 2'b11;
      sda_prev_q <= 2'b11;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_prev_q <= {scl_prev_q[0], scl_sync_q[1]};
      sda_prev_q <= {sda_prev_q[0], sda_sync_q[1]};
      scl_flt_q  <= scl_cur;
      sda_flt_q  <= sda_cur;
    end
  end
`else
  assign scl_cur = scl_sync_q[1];
  assign sda_cur = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_cur & ~scl_hist_q;
  assign scl_fall  = ~scl_cur & scl_hist_q;
  assign start_det = scl_cur & scl_hist_q & sda_hist_q & ~sda_cur;
  assign stop_det  = scl_cur & scl_hist_q & ~sda_hist_q & sda_cur;

  // Protocol state. sh_q holds 7 bits: received bits during RX, remaining bits during TX.
  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [6:0]        sh_q, sh_d;
  logic              rw_q, rw_d;
  logic              phase_q, phase_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_valid_q, wr_valid_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        regs_q [0:(1<<REG_AW)-1];
  logic [7:0]        rx_byte, tx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      sh_q       <= 7'd0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // The bank is written in the cycle after wr_valid rises, so a local read
  // during the wr_valid cycle still sees the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << REG_AW); i++) regs_q[i] <= 8'h00;
    end else if (wr_valid_q) begin
      regs_q[wr_addr_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wdata_d    = wdata_q;
    rx_byte    = {sh_q, sda_cur};
    tx_byte    = regs_q[ptr_q];

    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = 3'd0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 3'd0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_ADDR: begin
          if (scl_rise) begin
            sh_d  = rx_byte[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d    = rx_byte[0];
              state_d = (rx_byte[7:1] == SLAVE_ADDR) ? ST_ACK_A : ST_IDLE;
            end
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            sh_d  = rx_byte[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_d   = rx_byte[REG_AW-1:0];
              state_d = ST_ACK_W;
            end
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            sh_d  = rx_byte[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              wdata_d    = rx_byte;
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              ptr_d      = ptr_q + REG_AW'(1);
              state_d    = ST_ACK_W;
            end
          end
        end
        ST_ACK_A, ST_ACK_W: begin
          // phase_q marks that ACK is being driven; the following fall ends it.
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d  = 1'b0;
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              if (state_q == ST_ACK_A && rw_q) begin
                state_d  = ST_TX;
                sh_d     = tx_byte[6:0];
                sda_oe_d = ~tx_byte[7];
              end else if (state_q == ST_ACK_A) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + REG_AW'(1);
              cnt_d    = 3'd0;
              state_d  = ST_MACK;
            end else begin
              sda_oe_d = ~sh_q[6];
              sh_d     = {sh_q[5:0], 1'b0};
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end
        ST_MACK: begin
          // phase_q records a master ACK; the next byte starts on the following fall.
          if (scl_rise) begin
            if (sda_cur) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            phase_d  = 1'b0;
            state_d  = ST_TX;
            sh_d     = tx_byte[6:0];
            sda_oe_d = ~tx_byte[7];
            cnt_d    = 3'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // wr_valid is a single-cycle event with no backpressure: the consumer
  // must take wr_addr in the cycle wr_valid is high.
  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign reg_data    = regs_q[reg_addr];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_twi_slave.sv
// Bench for twi_slave: a bit-banged TWI master, a transaction-level register model and a per-cycle compare process.
module tb_twi_slave;

  localparam int Q = 6;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [1:0] reg_addr = 2'd0;
  logic [7:0] reg_data;
  logic       wr_valid;
  logic [1:0] wr_addr;
  logic       busy;
  logic [2:0] dbg_state;

  assign sda_line = sda_m & ~sda_oe;

  twi_slave #(.SLAVE_ADDR(7'h28), .REG_AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // Scoreboard state
  int         errors = 0;
  int         checks = 0;
  logic [9:0] exp_q[$];
  logic [7:0] m_regs [4];
  logic [1:0] m_ptr = 2'd0;
  logic [7:0] shadow [4];
  logic       quiet = 1'b0;
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver tasks: every bit begins just after SCL fell.
  task automatic clock_bit(input logic b, output logic r);
    wait_clk(Q); sda_m = b;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); r = sda_line;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      wait_clk(Q); sda_m = 1'b1;
      wait_clk(Q); scl_m = 1'b1;
      wait_clk(2*Q);
    end
    sda_m = 1'b0;
    wait_clk(2*Q); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(2*Q); sda_m = 1'b1;
    wait_clk(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      b[i] = r;
    end
    clock_bit(nack, r);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, dbg_state, S_IDLE);
    chk({tag, "_sda_oe"}, sda_oe, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Write transaction: pointer byte then n data bytes from wbuf.
  task automatic tx_write(input logic [6:0] a, input logic [7:0] p, input int n);
    logic ack;
    logic match;
    match = (a == 7'h28);
    quiet = !match;
    bus_start();
    write_byte({a, 1'b0}, ack);
    chk("addr_ack", ack, !match);
    if (match) chk("busy_after_match", busy, 1'b1);
    write_byte(p, ack);
    chk("ptr_ack", ack, !match);
    if (match) m_ptr = p[1:0];
    for (int i = 0; i < n; i++) begin
      if (match) begin
        exp_q.push_back({m_ptr, wbuf[i]});
        m_regs[m_ptr] = wbuf[i];
        m_ptr = m_ptr + 2'd1;
      end
      write_byte(wbuf[i], ack);
      chk("data_ack", ack, !match);
    end
    bus_stop();
    chk_idle("after_write");
    quiet = 1'b0;
  endtask

  // Read transaction, optionally setting the pointer first via repeated START.
  task automatic tx_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    bus_start();
    if (set_ptr) begin
      write_byte(8'h50, ack);
      chk("rd_waddr_ack", ack, 1'b0);
      write_byte(p, ack);
      chk("rd_ptr_ack", ack, 1'b0);
      m_ptr = p[1:0];
      bus_start();
    end
    write_byte(8'h51, ack);
    chk("rd_addr_ack", ack, 1'b0);
    chk("rd_busy", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      rbuf[i] = b;
      chk("read_data", b, m_regs[m_ptr]);
      m_ptr = m_ptr + 2'd1;
    end
    chk_idle("after_nack");
    bus_stop();
    chk("after_read_state", dbg_state, S_IDLE);
  endtask

  // Compare process: local read port and write events, every cycle.
  initial begin
    logic [9:0] e;
    for (int i = 0; i < 4; i++) shadow[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 4; i++) shadow[i] = 8'h00;
        exp_q.delete();
      end else begin
        chk("reg_data", reg_data, shadow[reg_addr]);
        if (quiet) begin
          chk("quiet_sda_oe", sda_oe, 1'b0);
          chk("quiet_busy", busy, 1'b0);
        end
        if (wr_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr_valid: got wr_addr %0h expected no write at %0t", wr_addr, $time);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e[9:8]);
            shadow[e[9:8]] = e[7:0];
          end
        end
      end
      reg_addr = 2'($urandom_range(0, 3));
    end
  end

  initial begin
    logic r;
    logic ack;
    logic seen;
    logic exp_seen;
    logic [6:0] a;
    int kind;
    int n;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

    wait_clk(4);
    rst = 1'b0;
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_addr", wr_addr, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, S_IDLE);
    wait_clk(20);

    // Write with pointer
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    tx_write(7'h28, 8'h01, 2);
    chk("exp_q_drained_1", exp_q.size(), 0);

    // Read via repeated START, ACK ACK NACK
    tx_read(1'b1, 8'h01, 3);
    chk("plan_read0", rbuf[0], 8'hA5);
    chk("plan_read1", rbuf[1], 8'h3C);
    chk("plan_read2", rbuf[2], 8'h00);
    chk("plan_ptr_wrapped", m_ptr, 2'd0);
    tx_read(1'b0, 8'h00, 1);
    chk("plan_read_ptr0", rbuf[0], 8'h00);

    // Address mismatch
    wbuf[0] = 8'hFF;
    quiet = 1'b1;
    bus_start();
    write_byte(8'h52, ack);
    chk("mismatch_ack", ack, 1'b1);
    write_byte(8'hFF, ack);
    chk("mismatch_data_ack", ack, 1'b1);
    bus_stop();
    chk_idle("mismatch");
    quiet = 1'b0;

    // Wrap-around write
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    tx_write(7'h28, 8'h03, 2);
    tx_read(1'b1, 8'h03, 2);
    chk("wrap_reg3", rbuf[0], 8'h11);
    chk("wrap_reg0", rbuf[1], 8'h22);

    // STOP after 4 data bits: no write, pointer kept at 2
    bus_start();
    write_byte(8'h50, ack);
    chk("abort_addr_ack", ack, 1'b0);
    write_byte(8'h02, ack);
    chk("abort_ptr_ack", ack, 1'b0);
    m_ptr = 2'd2;
    for (int i = 0; i < 4; i++) clock_bit(i[0], r);
    bus_stop();
    chk_idle("abort");
    tx_read(1'b0, 8'h00, 2);
    chk("abort_reg2", rbuf[0], 8'h3C);

    // Randomised traffic
    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(0, 255));
      case (kind)
        0: tx_write(7'h28, 8'($urandom_range(0, 255)), n);
        1: tx_read(1'b1, 8'($urandom_range(0, 255)), n);
        2: tx_read(1'b0, 8'h00, n);
        default: begin
          do a = 7'($urandom_range(0, 127)); while (a == 7'h28);
          tx_write(a, 8'($urandom_range(0, 255)), n);
        end
      endcase
      wait_clk($urandom_range(2, 30));
    end
    chk("exp_q_drained_2", exp_q.size(), 0);

    // Reset in the middle of a TX byte
    wbuf[0] = 8'h00;
    bus_start();
    write_byte(8'h51, ack);
    chk("midtx_addr_ack", ack, 1'b0);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, r);
    rst = 1'b1;
    wait_clk(1);
    chk("midtx_rst_sda_oe", sda_oe, 1'b0);
    chk("midtx_rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_ptr = 2'd0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(4*Q);
    tx_read(1'b1, 8'h00, 4);
    for (int i = 0; i < 4; i++) chk("midtx_reg_cleared", rbuf[i], 8'h00);

    // Short SDA glitch while SCL high in IDLE
    seen = 1'b0;
    wait_clk(10);
    sda_m = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) sda_m = 1'b1;
      wait_clk(1);
      if (dbg_state == S_ADDR) seen = 1'b1;
    end
`ifdef TWI_SLAVE_FILTER_EN
    exp_seen = 1'b0;
`else
    exp_seen = 1'b1;
`endif
    chk("glitch_start_seen", seen, exp_seen);
    chk("glitch_end_state", dbg_state, S_IDLE);

    wait_clk(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
